// File: rtl/inst_decode_queue.sv
// Instruction buffer between fetch and issue: a circular FIFO of (pc, inst)
// pairs, decoded into RV32I fields and a sign-extended immediate at write time.
module inst_decode_queue #(
  parameter int INST_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 17,
  parameter int OPCODE_WIDTH     = 7,
  parameter int REG_NUM_WIDTH    = 5,
  parameter int IMM_WIDTH        = 32,
  parameter int QUEUE_ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rdy,
  input  logic                          flush,
  input  logic                          in_valid,
  input  logic [ADDR_WIDTH+INST_WIDTH-1:0] in_entry,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_WIDTH-1:0]         out_pc,
  output logic [OPCODE_WIDTH-1:0]       out_opcode,
  output logic [2:0]                    out_funct3,
  output logic                          out_funct7b5,
  output logic [REG_NUM_WIDTH-1:0]      out_rs1,
  output logic [REG_NUM_WIDTH-1:0]      out_rs2,
  output logic [REG_NUM_WIDTH-1:0]      out_rd,
  output logic [IMM_WIDTH-1:0]          out_imm,
  output logic                          out_illegal,
  output logic [QUEUE_ADDR_WIDTH:0]     count
);

  localparam int DEPTH = 2 ** QUEUE_ADDR_WIDTH;
  localparam logic [QUEUE_ADDR_WIDTH:0] FULL_CNT = {1'b1, {QUEUE_ADDR_WIDTH{1'b0}}};

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    pc;
    logic [OPCODE_WIDTH-1:0]  opcode;
    logic [2:0]               funct3;
    logic                     funct7b5;
    logic [REG_NUM_WIDTH-1:0] rs1;
    logic [REG_NUM_WIDTH-1:0] rs2;
    logic [REG_NUM_WIDTH-1:0] rd;
    logic [IMM_WIDTH-1:0]     imm;
    logic                     illegal;
  } entry_t;

  entry_t                      mem_q [DEPTH];
  entry_t                      wr_entry;
  entry_t                      head_entry;
  logic [QUEUE_ADDR_WIDTH-1:0] head_q, head_d;
  logic [QUEUE_ADDR_WIDTH-1:0] tail_q, tail_d;
  logic [QUEUE_ADDR_WIDTH:0]   count_q, count_d;
  logic [INST_WIDTH-1:0]       inst;
  logic signed [31:0]          imm32;
  logic                        illegal;
  logic                        enq, deq;

  assign inst = in_entry[INST_WIDTH-1:0];

  always_comb begin
    imm32   = '0;
    illegal = 1'b0;
    case (inst[6:0])
      7'b0110111, 7'b0010111: imm32 = {inst[31:12], 12'b0};
      7'b1101111: imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      7'b1100111, 7'b0000011, 7'b0010011: imm32 = {{20{inst[31]}}, inst[31:20]};
      7'b1100011: imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      7'b0100011: imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'b0110011: imm32 = '0;
      default:    illegal = 1'b1;
    endcase
  end

  always_comb begin
    wr_entry          = '0;
    wr_entry.pc       = in_entry[ADDR_WIDTH+INST_WIDTH-1 -: ADDR_WIDTH];
    wr_entry.opcode   = inst[OPCODE_WIDTH-1:0];
    wr_entry.funct3   = inst[14:12];
    wr_entry.funct7b5 = inst[30];
    wr_entry.rs1      = inst[15 +: REG_NUM_WIDTH];
    wr_entry.rs2      = inst[20 +: REG_NUM_WIDTH];
    wr_entry.rd       = inst[7 +: REG_NUM_WIDTH];
    // signed cast sign-extends the 32-bit immediate to any IMM_WIDTH
    wr_entry.imm      = IMM_WIDTH'(imm32);
    wr_entry.illegal  = illegal;
  end

  assign in_ready  = rst_n && (count_q != FULL_CNT);
  assign out_valid = rst_n && (count_q != '0);
  assign enq       = rdy && in_valid && in_ready && !flush;
  assign deq       = rdy && out_valid && out_ready && !flush;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq) tail_d = tail_q + 1'b1;
      if (deq) head_d = head_q + 1'b1;
      if (enq && !deq) count_d = count_q + 1'b1;
      else if (deq && !enq) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (enq) mem_q[tail_q] <= wr_entry;
    end
  end

  // outputs read as zero throughout reset, not just after the first edge
  assign head_entry   = rst_n ? mem_q[head_q] : '0;
  assign count        = rst_n ? count_q : '0;
  assign out_pc       = head_entry.pc;
  assign out_opcode   = head_entry.opcode;
  assign out_funct3   = head_entry.funct3;
  assign out_funct7b5 = head_entry.funct7b5;
  assign out_rs1      = head_entry.rs1;
  assign out_rs2      = head_entry.rs2;
  assign out_rd       = head_entry.rd;
  assign out_imm      = head_entry.imm;
  assign out_illegal  = head_entry.illegal;

endmodule

// File: tb/tb_inst_decode_queue.sv
// Bench for inst_decode_queue: a scoreboard of expected decoded entries is
// pushed when an offer should be accepted and compared against the head.
module tb_inst_decode_queue;

  logic        clk = 1'b0;
  logic        rst_n, rdy, flush, in_valid, out_ready;
  logic [48:0] in_entry;
  logic        in_ready, out_valid;
  logic [16:0] out_pc;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_funct7b5;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [4:0]  count;

  typedef struct packed {
    logic [16:0] pc;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        ill;
  } exp_t;

  exp_t sbq[$];
  exp_t nxt;
  int   exp_count = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  inst_decode_queue dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_entry(in_entry), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7b5(out_funct7b5),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_illegal(out_illegal), .count(count)
  );

  always #5 clk = ~clk;

  task automatic set_in(input logic v, input logic [16:0] pc, input logic [31:0] inst,
                        input logic [31:0] imm, input logic ill);
    in_valid  = v;
    in_entry  = {pc, inst};
    nxt.pc    = pc;
    nxt.op    = inst[6:0];
    nxt.f3    = inst[14:12];
    nxt.f7b5  = inst[30];
    nxt.rs1   = inst[19:15];
    nxt.rs2   = inst[24:20];
    nxt.rd    = inst[11:7];
    nxt.imm   = imm;
    nxt.ill   = ill;
  endtask

  // One clock: check status and head against the model, advance the model, clock.
  task automatic cycle();
    exp_t e;
    bit   enq, deq;
    logic [4:0] ec;
    #1;
    ec = rst_n ? 5'(exp_count) : 5'd0;
    n_cmp++;
    if (count !== ec) begin
      n_err++; $display("FAIL count: got %0d want %0d", count, ec);
    end
    n_cmp++;
    if (in_ready !== (rst_n && exp_count != 16)) begin
      n_err++; $display("FAIL in_ready: got %b want %b", in_ready, rst_n && exp_count != 16);
    end
    n_cmp++;
    if (out_valid !== (rst_n && exp_count != 0)) begin
      n_err++; $display("FAIL out_valid: got %b want %b", out_valid, rst_n && exp_count != 0);
    end
    if (!rst_n) begin
      n_cmp++;
      if ({out_pc, out_opcode, out_rs1, out_rs2, out_rd, out_imm, out_illegal} !== '0) begin
        n_err++; $display("FAIL reset_fields: pc %h imm %h not zero", out_pc, out_imm);
      end
    end else if (exp_count != 0) begin
      e = sbq[0];
      n_cmp++;
      if (out_pc !== e.pc || out_opcode !== e.op || out_funct3 !== e.f3 ||
          out_funct7b5 !== e.f7b5 || out_rs1 !== e.rs1 || out_rs2 !== e.rs2 ||
          out_rd !== e.rd || out_imm !== e.imm || out_illegal !== e.ill) begin
        n_err++;
        $display("FAIL head: got pc=%h op=%b rs1=%0d rs2=%0d rd=%0d imm=%h ill=%b want pc=%h op=%b rs1=%0d rs2=%0d rd=%0d imm=%h ill=%b",
                 out_pc, out_opcode, out_rs1, out_rs2, out_rd, out_imm, out_illegal,
                 e.pc, e.op, e.rs1, e.rs2, e.rd, e.imm, e.ill);
      end
    end
    if (!rst_n) begin
      sbq.delete(); exp_count = 0;
    end else if (rdy) begin
      if (flush) begin
        sbq.delete(); exp_count = 0;
      end else begin
        deq = out_ready && exp_count != 0;
        enq = in_valid && exp_count != 16;
        if (deq) begin void'(sbq.pop_front()); exp_count--; end
        if (enq) begin sbq.push_back(nxt); exp_count++; end
      end
    end
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] addi_inst(input int imm);
    return {12'(imm), 5'd2, 3'b000, 5'd1, 7'b0010011};
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; out_ready = 1'b0;
    set_in(1'b1, 17'h1, addi_inst(1), 32'd1, 1'b0);
    cycle(); cycle();
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    rst_n = 1'b1;
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    cycle(); cycle();
    n_cmp++;
    if (count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL idle: got count=%0d ov=%b ir=%b want 0 0 1", count, out_valid, in_ready);
    end
  endtask

  task automatic test_addi();
    set_in(1'b1, 17'h100, 32'hFFF10093, 32'hFFFFFFFF, 1'b0);
    cycle();
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if (out_rs1 !== 5'd2 || out_rd !== 5'd1 || out_imm !== 32'hFFFFFFFF ||
        out_opcode !== 7'b0010011 || count !== 5'd1) begin
      n_err++; $display("FAIL addi: got rs1=%0d rd=%0d imm=%h op=%b cnt=%0d want 2 1 ffffffff 0010011 1",
                        out_rs1, out_rd, out_imm, out_opcode, count);
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_decode_sweep();
    logic [31:0] insts [5] = '{32'hFFDFF06F, 32'h00208463, 32'hFE20AE23, 32'h123452B7, 32'h00000073};
    logic [31:0] imms  [5] = '{32'hFFFFFFFC, 32'h00000008, 32'hFFFFFFFC, 32'h12345000, 32'h00000000};
    logic        ills  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 17'(16'h0200 + i), insts[i], imms[i], ills[i]);
      cycle();
      n_cmp++;
      if (out_imm !== imms[i] || out_illegal !== ills[i]) begin
        n_err++; $display("FAIL decode%0d: got imm=%h ill=%b want imm=%h ill=%b",
                          i, out_imm, out_illegal, imms[i], ills[i]);
      end
    end
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 17'(i), addi_inst(i), 32'(i), 1'b0);
      cycle();
    end
    n_cmp++;
    if (in_ready !== 1'b0 || count !== 5'd16) begin
      n_err++; $display("FAIL full: got ir=%b cnt=%0d want 0 16", in_ready, count);
    end
    set_in(1'b1, 17'd99, addi_inst(99), 32'd99, 1'b0);
    cycle();
    n_cmp++;
    if (count !== 5'd16) begin n_err++; $display("FAIL overfill: got cnt=%0d want 16", count); end
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (out_pc !== 17'(i) || count !== 5'(16 - i)) begin
        n_err++; $display("FAIL drain%0d: got pc=%0d cnt=%0d want pc=%0d cnt=%0d",
                          i, out_pc, count, i, 16 - i);
      end
      cycle();
    end
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 17'(32 + i), addi_inst(-i), -32'(i), 1'b0);
      out_ready = (i % 3 != 0);
      cycle();
    end
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    n_cmp++;
    if (count !== 5'd0) begin n_err++; $display("FAIL refill_drain: got cnt=%0d want 0", count); end
    out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 17'(17'h300 + i), addi_inst(i), 32'(i), 1'b0);
      cycle();
    end
    set_in(1'b1, 17'h303, addi_inst(3), 32'd3, 1'b0);
    out_ready = 1'b1;
    cycle();
    n_cmp++;
    if (count !== 5'd3 || out_pc !== 17'h301) begin
      n_err++; $display("FAIL simul: got cnt=%0d pc=%h want 3 301", count, out_pc);
    end
    rdy = 1'b0;
    set_in(1'b1, 17'h304, addi_inst(4), 32'd4, 1'b0);
    cycle(); cycle();
    n_cmp++;
    if (count !== 5'd3 || out_pc !== 17'h301) begin
      n_err++; $display("FAIL freeze: got cnt=%0d pc=%h want 3 301", count, out_pc);
    end
    rdy = 1'b1;
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    cycle(); cycle(); cycle();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 17'(17'h400 + i), addi_inst(i), 32'(i), 1'b0);
      cycle();
    end
    flush = 1'b1;
    set_in(1'b1, 17'h4FF, addi_inst(7), 32'd7, 1'b0);
    cycle();
    flush = 1'b0;
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if (count !== 5'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL flush: got cnt=%0d ov=%b ir=%b want 0 0 1", count, out_valid, in_ready);
    end
    set_in(1'b1, 17'h500, 32'h00000033, 32'd0, 1'b0);
    cycle();
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    n_cmp++;
    if (out_pc !== 17'h500 || count !== 5'd1) begin
      n_err++; $display("FAIL post_flush: got pc=%h cnt=%0d want 500 1", out_pc, count);
    end
  endtask

  task automatic test_reset_mid();
    set_in(1'b1, 17'h600, addi_inst(5), 32'd5, 1'b0);
    cycle(); cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    cycle();
    n_cmp++;
    if (count !== 5'd0 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL mid_reset: got cnt=%0d ov=%b want 0 0", count, out_valid);
    end
    set_in(1'b1, 17'h700, 32'hFE20AE23, 32'hFFFFFFFC, 1'b0);
    cycle();
    set_in(1'b0, 17'h0, 32'h0, 32'h0, 1'b0);
    cycle();
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_entry = '0;
    @(posedge clk); #1;
    test_reset();
    test_addi();
    test_decode_sweep();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
